// File: rtl/seq_mac_neuron.sv
// Time-multiplexed fixed-point neuron: one MAC per beat, then bias, round, saturate/wrap, ReLU.
// Optional clamping is enabled by defining SEQ_MAC_NEURON_SAT_EN; otherwise the result wraps.
module seq_mac_neuron #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned WEIGHT_W  = 16,
    parameter int unsigned BIAS_W    = 32,
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned N_INPUTS  = 16,
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned OUT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_relu_i,
    input  logic [BIAS_W-1:0]   bias_i,
    input  logic                x_valid_i,
    output logic                x_ready_o,
    input  logic [DATA_W-1:0]   x_data_i,
    input  logic [WEIGHT_W-1:0] w_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [OUT_W-1:0]    out_data_o,
    output logic                out_sat_o,
    output logic                busy_o
);

    localparam int unsigned PROD_W  = DATA_W + WEIGHT_W;
    localparam int unsigned CNT_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam int unsigned ACC_MIN = PROD_W + $clog2(N_INPUTS) + 1;
    // Two guard bits: one for the bias add, one for the rounding constant.
    localparam int unsigned SUM_W   = ACC_W + 2;
    localparam logic [SUM_W-1:0] RND = SUM_W'(1) << (FRAC_BITS - 1);

    if (FRAC_BITS < 1) begin : g_bad_frac
        $error("seq_mac_neuron: FRAC_BITS must be >= 1");
    end
    if (N_INPUTS < 1) begin : g_bad_n
        $error("seq_mac_neuron: N_INPUTS must be >= 1");
    end
    if (ACC_W < ACC_MIN || ACC_W < BIAS_W + 1) begin : g_bad_acc
        $error("seq_mac_neuron: ACC_W too narrow for the product sum or the bias");
    end
    if (OUT_W >= SUM_W) begin : g_bad_out
        $error("seq_mac_neuron: OUT_W must be narrower than ACC_W + 2");
    end

    typedef enum logic [1:0] {StCollect, StFinal, StOut} state_e;

    state_e                   state_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     x_ready_q;
    logic                     out_valid_q;
    logic [OUT_W-1:0]         out_data_q;
    logic                     out_sat_q;
    logic                     busy_q;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [SUM_W-1:0]  sum;
    logic [OUT_W-1:0]         sat_val;
    logic                     sat_flag;
    logic [OUT_W-1:0]         res_val;

    assign prod     = $signed(x_data_i) * $signed(w_data_i);
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign sum      = $signed({{2{acc_q[ACC_W-1]}}, acc_q})
                    + $signed({{(SUM_W - BIAS_W){bias_i[BIAS_W-1]}}, bias_i})
                    + $signed(RND);

`ifdef SEQ_MAC_NEURON_SAT_EN
    localparam logic signed [SUM_W-1:0] OUT_MAX = {{(SUM_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] OUT_MIN = {{(SUM_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [SUM_W-1:0] r;
    assign r = sum >>> FRAC_BITS;

    always_comb begin
        sat_val  = r[OUT_W-1:0];
        sat_flag = 1'b0;
        if (r > OUT_MAX) begin
            sat_val  = OUT_MAX[OUT_W-1:0];
            sat_flag = 1'b1;
        end else if (r < OUT_MIN) begin
            sat_val  = OUT_MIN[OUT_W-1:0];
            sat_flag = 1'b1;
        end
    end
`else
    assign sat_val  = OUT_W'(sum >>> FRAC_BITS);
    assign sat_flag = 1'b0;
`endif

    assign res_val = (cfg_relu_i && sat_val[OUT_W-1]) ? '0 : sat_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StCollect;
            acc_q       <= '0;
            cnt_q       <= '0;
            x_ready_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StCollect: begin
                    if (x_valid_i && x_ready_q) begin
                        acc_q  <= acc_q + prod_ext;
                        busy_q <= 1'b1;
                        if (cnt_q == CNT_W'(N_INPUTS - 1)) begin
                            cnt_q     <= '0;
                            x_ready_q <= 1'b0;
                            state_q   <= StFinal;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        // Covers the first cycle after reset release.
                        x_ready_q <= 1'b1;
                    end
                end
                StFinal: begin
                    out_data_q  <= res_val;
                    out_sat_q   <= sat_flag;
                    out_valid_q <= 1'b1;
                    acc_q       <= '0;
                    state_q     <= StOut;
                end
                StOut: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        x_ready_q   <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StCollect;
                    end
                end
                default: begin
                    state_q <= StCollect;
                end
            endcase
        end
    end

    assign x_ready_o   = x_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sat_o   = out_sat_q;
    assign busy_o      = busy_q;

endmodule
